// File: rtl/irq_responder_if.sv
// Core-side interrupt handshake bundle: pending bitmap and mask in, request/ack/status out.
// The slave modport is the responder; the master modport is the core/controller side.
interface irq_responder_if #(
  parameter int CNT_W = 16
);
  logic [31:0]      i_irq;
  logic             i_mask_wr;
  logic [31:0]      i_mask_wdata;
  logic [31:0]      o_mask;
  logic             o_irq_req;
  logic [4:0]       o_irq_id;
  logic             i_irq_take;
  logic             i_irq_ret;
  logic             o_irq_ack;
  logic [4:0]       o_irq_ack_id;
  logic             o_busy;
  logic [CNT_W-1:0] o_serviced_cnt;

  modport slave (
    input  i_irq, i_mask_wr, i_mask_wdata, i_irq_take, i_irq_ret,
    output o_mask, o_irq_req, o_irq_id, o_irq_ack, o_irq_ack_id, o_busy, o_serviced_cnt
  );

  modport master (
    output i_irq, i_mask_wr, i_mask_wdata, i_irq_take, i_irq_ret,
    input  o_mask, o_irq_req, o_irq_id, o_irq_ack, o_irq_ack_id, o_busy, o_serviced_cnt
  );
endinterface

// File: rtl/irq_responder.sv
// Masks the pending bitmap, issues one lowest-index request at a time to the core,
// acks it to the controller on take, and blocks new requests until the handler returns.
module irq_responder #(
  parameter logic [31:0] MASK_RST = 32'h0000_0000,
  parameter int          CNT_W    = 16
) (
  input logic          i_clk,
  input logic          i_rst_n,
  irq_responder_if.slave bus
);
  typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;

  state_t           state_q, state_d;
  logic [31:0]      mask_q, mask_d;
  logic             req_q, req_d;
  logic [4:0]       id_q, id_d;
  logic             ack_q, ack_d;
  logic [4:0]       ack_id_q, ack_id_d;
  logic             busy_q, busy_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [31:0] eff;
  logic [4:0]  win_id;

  assign eff = bus.i_irq & ~mask_q;

  // Scan downward so the last hit, i.e. the lowest set index, wins.
  always_comb begin
    win_id = 5'd0;
    for (int i = 31; i >= 0; i--) begin
      if (eff[i]) win_id = 5'(i);
    end
  end

  always_comb begin
    state_d  = state_q;
    mask_d   = bus.i_mask_wr ? bus.i_mask_wdata : mask_q;
    req_d    = req_q;
    id_d     = id_q;
    ack_d    = 1'b0;
    ack_id_d = ack_id_q;
    busy_d   = busy_q;
    cnt_d    = cnt_q;
    case (state_q)
      IDLE: begin
        if (eff != 32'd0) begin
          req_d   = 1'b1;
          id_d    = win_id;
          state_d = REQ;
        end
      end
      REQ: begin
        // Request is latched; mask or i_irq changes cannot withdraw it.
        if (bus.i_irq_take) begin
          req_d    = 1'b0;
          ack_d    = 1'b1;
          ack_id_d = id_q;
          cnt_d    = cnt_q + 1'b1;
          busy_d   = 1'b1;
          state_d  = SERVICE;
        end
      end
      SERVICE: begin
        if (bus.i_irq_ret) begin
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= IDLE;
      mask_q   <= MASK_RST;
      req_q    <= 1'b0;
      id_q     <= 5'd0;
      ack_q    <= 1'b0;
      ack_id_q <= 5'd0;
      busy_q   <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      mask_q   <= mask_d;
      req_q    <= req_d;
      id_q     <= id_d;
      ack_q    <= ack_d;
      ack_id_q <= ack_id_d;
      busy_q   <= busy_d;
      cnt_q    <= cnt_d;
    end
  end

  assign bus.o_mask         = mask_q;
  assign bus.o_irq_req      = req_q;
  assign bus.o_irq_id       = id_q;
  assign bus.o_irq_ack      = ack_q;
  assign bus.o_irq_ack_id   = ack_id_q;
  assign bus.o_busy         = busy_q;
  assign bus.o_serviced_cnt = cnt_q;
endmodule

// File: tb/tb_irq_responder.sv
// Directed bench for irq_responder built with a 4-bit serviced counter.
module tb_irq_responder;
  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  irq_responder_if #(.CNT_W(4)) bus ();

  irq_responder #(.MASK_RST(32'h0000_0000), .CNT_W(4)) dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_req"},  32'(bus.o_irq_req), 32'd0);
    check({tag, "_id"},   32'(bus.o_irq_id), 32'd0);
    check({tag, "_ack"},  32'(bus.o_irq_ack), 32'd0);
    check({tag, "_ackid"}, 32'(bus.o_irq_ack_id), 32'd0);
    check({tag, "_busy"}, 32'(bus.o_busy), 32'd0);
    check({tag, "_cnt"},  32'(bus.o_serviced_cnt), 32'd0);
    check({tag, "_mask"}, bus.o_mask, 32'd0);
  endtask

  initial begin
    logic [3:0] exp_cnt;
    checks = 0;
    failures = 0;
    rst_n = 1'b0;
    bus.i_irq = 32'd0;
    bus.i_mask_wr = 1'b0;
    bus.i_mask_wdata = 32'd0;
    bus.i_irq_take = 1'b0;
    bus.i_irq_ret = 1'b0;
    step();
    step();
    check_idle_outputs("rst");
    rst_n = 1'b1;
    step();
    check("idle_noreq", 32'(bus.o_irq_req), 32'd0);

    // Lowest of bits 3,4 wins, one cycle latency.
    bus.i_irq = 32'h0000_0018;
    step();
    $display("txn irq=18 -> req=%0d id=%0d", bus.o_irq_req, bus.o_irq_id);
    check("t1_req", 32'(bus.o_irq_req), 32'd1);
    check("t1_id", 32'(bus.o_irq_id), 32'd3);
    step();
    check("t1_hold_id", 32'(bus.o_irq_id), 32'd3);
    bus.i_irq_take = 1'b1;
    step();
    $display("txn take -> ack=%0d ack_id=%0d busy=%0d cnt=%0d", bus.o_irq_ack, bus.o_irq_ack_id, bus.o_busy, bus.o_serviced_cnt);
    bus.i_irq_take = 1'b0;
    bus.i_irq = 32'h0000_0010;
    check("t1_ack", 32'(bus.o_irq_ack), 32'd1);
    check("t1_ackid", 32'(bus.o_irq_ack_id), 32'd3);
    check("t1_busy", 32'(bus.o_busy), 32'd1);
    check("t1_cnt", 32'(bus.o_serviced_cnt), 32'd1);
    check("t1_req_drop", 32'(bus.o_irq_req), 32'd0);
    step();
    check("t1_ack_pulse", 32'(bus.o_irq_ack), 32'd0);

    // Bit 0 pends during service: no request until after ret.
    bus.i_irq = 32'h0000_0011;
    step();
    step();
    check("t2_noreq_busy", 32'(bus.o_irq_req), 32'd0);
    bus.i_irq_ret = 1'b1;
    step();
    bus.i_irq_ret = 1'b0;
    $display("txn ret -> busy=%0d req=%0d", bus.o_busy, bus.o_irq_req);
    check("t2_busy_clr", 32'(bus.o_busy), 32'd0);
    check("t2_req_gap", 32'(bus.o_irq_req), 32'd0);
    step();
    $display("txn rearb -> req=%0d id=%0d", bus.o_irq_req, bus.o_irq_id);
    check("t2_req", 32'(bus.o_irq_req), 32'd1);
    check("t2_id", 32'(bus.o_irq_id), 32'd0);
    bus.i_irq_take = 1'b1;
    step();
    bus.i_irq_take = 1'b0;
    bus.i_irq = 32'd0;
    check("t2_ackid", 32'(bus.o_irq_ack_id), 32'd0);
    check("t2_cnt", 32'(bus.o_serviced_cnt), 32'd2);
    bus.i_irq_ret = 1'b1;
    step();
    bus.i_irq_ret = 1'b0;
    step();

    // Strobes in IDLE are ignored.
    bus.i_irq_take = 1'b1;
    bus.i_irq_ret = 1'b1;
    step();
    bus.i_irq_take = 1'b0;
    bus.i_irq_ret = 1'b0;
    step();
    check("t3_idle_req", 32'(bus.o_irq_req), 32'd0);
    check("t3_idle_ack", 32'(bus.o_irq_ack), 32'd0);
    check("t3_idle_busy", 32'(bus.o_busy), 32'd0);
    check("t3_idle_cnt", 32'(bus.o_serviced_cnt), 32'd2);

    // Mask bit 0 so bit 7 wins; then unmask while in REQ.
    bus.i_mask_wr = 1'b1;
    bus.i_mask_wdata = 32'h0000_0001;
    step();
    bus.i_mask_wr = 1'b0;
    check("t4_mask", bus.o_mask, 32'h0000_0001);
    bus.i_irq = 32'h0000_0081;
    step();
    $display("txn irq=81 mask=1 -> req=%0d id=%0d", bus.o_irq_req, bus.o_irq_id);
    check("t4_req", 32'(bus.o_irq_req), 32'd1);
    check("t4_id", 32'(bus.o_irq_id), 32'd7);
    bus.i_mask_wr = 1'b1;
    bus.i_mask_wdata = 32'd0;
    step();
    bus.i_mask_wr = 1'b0;
    check("t4_mask_clr", bus.o_mask, 32'd0);
    step();
    check("t4_id_hold", 32'(bus.o_irq_id), 32'd7);
    check("t4_req_hold", 32'(bus.o_irq_req), 32'd1);

    // Take and ret together in REQ: take wins, ret ignored.
    bus.i_irq_take = 1'b1;
    bus.i_irq_ret = 1'b1;
    step();
    bus.i_irq_take = 1'b0;
    bus.i_irq_ret = 1'b0;
    bus.i_irq = 32'd0;
    $display("txn take+ret -> ack=%0d ack_id=%0d busy=%0d", bus.o_irq_ack, bus.o_irq_ack_id, bus.o_busy);
    check("t5_ack", 32'(bus.o_irq_ack), 32'd1);
    check("t5_ackid", 32'(bus.o_irq_ack_id), 32'd7);
    check("t5_cnt", 32'(bus.o_serviced_cnt), 32'd3);
    step();
    check("t5_busy", 32'(bus.o_busy), 32'd1);
    bus.i_irq_take = 1'b1;
    step();
    bus.i_irq_take = 1'b0;
    check("t5_svc_take_ack", 32'(bus.o_irq_ack), 32'd0);
    check("t5_svc_take_cnt", 32'(bus.o_serviced_cnt), 32'd3);

    // Async reset mid-SERVICE, with a non-default mask loaded.
    bus.i_mask_wr = 1'b1;
    bus.i_mask_wdata = 32'h0000_00f0;
    step();
    bus.i_mask_wr = 1'b0;
    check("t6_mask_wr", bus.o_mask, 32'h0000_00f0);
    #2 rst_n = 1'b0;
    #1;
    check_idle_outputs("rst_svc");
    step();
    check("rst_svc_noack", 32'(bus.o_irq_ack), 32'd0);
    rst_n = 1'b1;

    // Async reset mid-REQ.
    bus.i_irq = 32'h0000_0004;
    step();
    check("t7_req", 32'(bus.o_irq_req), 32'd1);
    check("t7_id", 32'(bus.o_irq_id), 32'd2);
    #2 rst_n = 1'b0;
    #1;
    bus.i_irq = 32'd0;
    check_idle_outputs("rst_req");
    step();
    check("rst_req_noack", 32'(bus.o_irq_ack), 32'd0);
    rst_n = 1'b1;
    step();

    // 16 take/ret rounds with a 4-bit counter: 1..15 then wrap to 0.
    exp_cnt = 4'd0;
    for (int k = 0; k < 16; k++) begin
      bus.i_irq = 32'h0000_0001;
      step();
      bus.i_irq_take = 1'b1;
      step();
      bus.i_irq_take = 1'b0;
      bus.i_irq = 32'd0;
      exp_cnt = exp_cnt + 4'd1;
      $display("txn wrap round=%0d ack=%0d cnt=%0d", k, bus.o_irq_ack, bus.o_serviced_cnt);
      check("wrap_ack", 32'(bus.o_irq_ack), 32'd1);
      check("wrap_cnt", 32'(bus.o_serviced_cnt), 32'(exp_cnt));
      bus.i_irq_ret = 1'b1;
      step();
      bus.i_irq_ret = 1'b0;
      step();
    end
    check("wrap_final", 32'(bus.o_serviced_cnt), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
